// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 control sequencer: FSM states,
// opcode encodings, ALU function selects and ControlWord bit positions.
package legv8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM1,
    MEM2,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_ORR,
    OP_ADDI,
    OP_SUBI,
    OP_LDUR,
    OP_STUR,
    OP_ILLEGAL
  } op_t;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_ALU,
    IMM_MEM
  } imm_sel_t;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam int CW_DA       = 0;
  localparam int CW_SA       = 5;
  localparam int CW_SB       = 10;
  localparam int CW_W        = 15;
  localparam int CW_BSEL     = 16;
  localparam int CW_FS       = 17;
  localparam int CW_C0       = 22;
  localparam int CW_CS       = 23;
  localparam int CW_EN_ALU   = 24;
  localparam int CW_EN_B     = 25;
  localparam int CW_EN_ADDR  = 26;
  localparam int CW_SIZE     = 27;
  localparam int CW_WE       = 29;
  localparam int CW_RE       = 30;

  // opc is instr[31:21]; I-type opcodes occupy only the upper ten bits.
  function automatic op_t decode_op(input logic [10:0] opc);
    op_t op;
    if (opc == OPC_ADD)             op = OP_ADD;
    else if (opc == OPC_SUB)        op = OP_SUB;
    else if (opc == OPC_AND)        op = OP_AND;
    else if (opc == OPC_ORR)        op = OP_ORR;
    else if (opc[10:1] == OPC_ADDI) op = OP_ADDI;
    else if (opc[10:1] == OPC_SUBI) op = OP_SUBI;
    else if (opc == OPC_LDUR)       op = OP_LDUR;
    else if (opc == OPC_STUR)       op = OP_STUR;
    else                            op = OP_ILLEGAL;
    return op;
  endfunction

  function automatic logic is_mem_op(input op_t op);
    return (op == OP_LDUR) || (op == OP_STUR);
  endfunction

  function automatic logic is_imm_op(input op_t op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/legv8_imm_extend.sv
// Immediate generator: zero-extends the 12-bit ALU immediate or
// sign-extends the 9-bit D-type address offset, from instr[21:10].
import legv8_pkg::*;

module legv8_imm_extend (
  input  logic [11:0] instr_imm,
  input  imm_sel_t    imm_sel,
  output logic [63:0] constant
);

  // instr_imm[11:0] = instr[21:10]; the D-type offset instr[20:12] is instr_imm[10:2].
  always_comb begin
    constant = '0;
    unique case (imm_sel)
      IMM_ALU: constant = {52'b0, instr_imm};
      IMM_MEM: constant = {{55{instr_imm[10]}}, instr_imm[10:2]};
      default: constant = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer_legv8.sv
// Multi-cycle LEGv8 control sequencer: accepts one instruction at a time and
// steps the datapath through EXEC or MEM1/MEM2 via a combinational ControlWord.
import legv8_pkg::*;

module control_sequencer_legv8 #(
  parameter logic [1:0] MEM_SIZE = 2'b11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  status,
  output logic [31:0] ControlWord,
  output logic [63:0] constant,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  flags
);

  state_t      state;
  logic [31:0] instr_q;
  op_t         op;
  imm_sel_t    imm_sel;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [4:0]  alu_fs;
  logic        alu_c0;
  logic [31:0] cw;

  assign op = decode_op(instr_q[31:21]);
  assign rd = instr_q[4:0];
  assign rn = instr_q[9:5];
  assign rm = instr_q[20:16];

  // done, illegal and instr_ready are registered alongside the state so they
  // are valid for exactly the cycle the FSM sits in DONE / IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      instr_q     <= '0;
      flags       <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        DECODE: begin
          if (op == OP_ILLEGAL) begin
            state   <= DONE;
            done    <= 1'b1;
            illegal <= 1'b1;
          end else if (is_mem_op(op)) begin
            state <= MEM1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          flags <= status;
          state <= DONE;
          done  <= 1'b1;
        end
        MEM1: state <= MEM2;
        MEM2: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    alu_fs = FS_ADD;
    alu_c0 = 1'b0;
    unique case (op)
      OP_SUB, OP_SUBI: begin
        alu_fs = FS_SUB;
        alu_c0 = 1'b1;
      end
      OP_AND:  alu_fs = FS_AND;
      OP_ORR:  alu_fs = FS_ORR;
      default: alu_fs = FS_ADD;
    endcase
  end

  // Loads and stores share the address path; they differ only in which
  // register field is routed and which memory strobe fires in MEM2.
  always_comb begin
    cw      = '0;
    imm_sel = IMM_NONE;
    unique case (state)
      EXEC: begin
        cw[CW_DA +: 5]  = rd;
        cw[CW_SA +: 5]  = rn;
        cw[CW_W]        = 1'b1;
        cw[CW_EN_ALU]   = 1'b1;
        cw[CW_FS +: 5]  = alu_fs;
        cw[CW_C0]       = alu_c0;
        if (is_imm_op(op)) begin
          cw[CW_BSEL] = 1'b1;
          imm_sel     = IMM_ALU;
        end else begin
          cw[CW_SB +: 5] = rm;
        end
      end
      MEM1, MEM2: begin
        cw[CW_SA +: 5]   = rn;
        cw[CW_BSEL]      = 1'b1;
        cw[CW_FS +: 5]   = FS_ADD;
        cw[CW_EN_ADDR]   = 1'b1;
        cw[CW_CS]        = 1'b1;
        cw[CW_SIZE +: 2] = MEM_SIZE;
        imm_sel          = IMM_MEM;
        if (op == OP_LDUR) begin
          cw[CW_DA +: 5] = rd;
          cw[CW_RE]      = 1'b1;
          cw[CW_W]       = (state == MEM2);
        end else begin
          cw[CW_SB +: 5] = rd;
          cw[CW_EN_B]    = 1'b1;
          cw[CW_WE]      = (state == MEM2);
        end
      end
      default: cw = '0;
    endcase
  end

  assign ControlWord = cw;

  legv8_imm_extend u_imm_extend (
    .instr_imm (instr_q[21:10]),
    .imm_sel   (imm_sel),
    .constant  (constant)
  );

endmodule

// File: tb/tb_control_sequencer_legv8.sv
// Scoreboard bench for control_sequencer_legv8: a bench-side model pushes the
// per-cycle expected outputs when an instruction is issued; each cycle pops one.
import legv8_pkg::*;

module tb_control_sequencer_legv8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  status = '0;
  logic [31:0] ControlWord;
  logic [63:0] constant;
  logic        done;
  logic        illegal;
  logic [3:0]  flags;

  control_sequencer_legv8 #(.MEM_SIZE(2'b11)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .status      (status),
    .ControlWord (ControlWord),
    .constant    (constant),
    .done        (done),
    .illegal     (illegal),
    .flags       (flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [98:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [98:0] obs;

  assign obs = {ControlWord, constant, done, illegal, instr_ready};

  function automatic logic [31:0] pack_cw(
    input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
    input logic w, input logic bsel, input logic [4:0] fs, input logic c0,
    input logic cs, input logic en_alu, input logic en_b, input logic en_addr,
    input logic [1:0] size, input logic we, input logic re);
    return {1'b0, re, we, size, en_addr, en_b, en_alu, cs, c0, fs, bsel, w, sb, sa, da};
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] cw, input logic [63:0] k,
                          input logic d, input logic ill, input logic rdy);
    exp_t x;
    x.tag = tag;
    x.v   = {cw, k, d, ill, rdy};
    exp_q.push_back(x);
  endtask

  // Expected outputs for every cycle from DECODE through the following IDLE.
  task automatic model_instr(input string name, input logic [31:0] ins);
    logic [10:0] o11;
    logic [9:0]  o10;
    logic [4:0]  rd, rn, rm;
    logic [63:0] kd;
    logic        ill;
    o11 = ins[31:21];
    o10 = ins[31:22];
    rd  = ins[4:0];
    rn  = ins[9:5];
    rm  = ins[20:16];
    kd  = {{55{ins[20]}}, ins[20:12]};
    ill = 1'b0;
    push_exp({name, ".decode"}, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    if (o11 == 11'b10001011000)
      push_exp({name, ".exec"}, pack_cw(rd, rn, rm, 1, 0, FS_ADD, 0, 0, 1, 0, 0, 2'b00, 0, 0), 64'h0, 0, 0, 0);
    else if (o11 == 11'b11001011000)
      push_exp({name, ".exec"}, pack_cw(rd, rn, rm, 1, 0, FS_SUB, 1, 0, 1, 0, 0, 2'b00, 0, 0), 64'h0, 0, 0, 0);
    else if (o11 == 11'b10001010000)
      push_exp({name, ".exec"}, pack_cw(rd, rn, rm, 1, 0, FS_AND, 0, 0, 1, 0, 0, 2'b00, 0, 0), 64'h0, 0, 0, 0);
    else if (o11 == 11'b10101010000)
      push_exp({name, ".exec"}, pack_cw(rd, rn, rm, 1, 0, FS_ORR, 0, 0, 1, 0, 0, 2'b00, 0, 0), 64'h0, 0, 0, 0);
    else if (o10 == 10'b1001000100)
      push_exp({name, ".exec"}, pack_cw(rd, rn, 5'd0, 1, 1, FS_ADD, 0, 0, 1, 0, 0, 2'b00, 0, 0),
               {52'b0, ins[21:10]}, 0, 0, 0);
    else if (o10 == 10'b1101000100)
      push_exp({name, ".exec"}, pack_cw(rd, rn, 5'd0, 1, 1, FS_SUB, 1, 0, 1, 0, 0, 2'b00, 0, 0),
               {52'b0, ins[21:10]}, 0, 0, 0);
    else if (o11 == 11'b11111000010) begin
      push_exp({name, ".mem1"}, pack_cw(rd, rn, 5'd0, 0, 1, FS_ADD, 0, 1, 0, 0, 1, 2'b11, 0, 1), kd, 0, 0, 0);
      push_exp({name, ".mem2"}, pack_cw(rd, rn, 5'd0, 1, 1, FS_ADD, 0, 1, 0, 0, 1, 2'b11, 0, 1), kd, 0, 0, 0);
    end else if (o11 == 11'b11111000000) begin
      push_exp({name, ".mem1"}, pack_cw(5'd0, rn, rd, 0, 1, FS_ADD, 0, 1, 0, 1, 1, 2'b11, 0, 0), kd, 0, 0, 0);
      push_exp({name, ".mem2"}, pack_cw(5'd0, rn, rd, 0, 1, FS_ADD, 0, 1, 0, 1, 1, 2'b11, 1, 0), kd, 0, 0, 0);
    end else
      ill = 1'b1;
    push_exp({name, ".done"}, 32'h0, 64'h0, 1'b1, ill, 1'b0);
    push_exp({name, ".idle"}, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic accept(input logic [31:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    instr       = 32'h8B020023;
    instr_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    push_exp("reset.hold", 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    push_exp("reset.release", 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_assert++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    n_assert++;
    if (flags !== 4'h0) begin n_fail++; $display("FAIL reset.flags: got %h expected 0", flags); end
    reset       = 1'b0;
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    n_assert++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
  endtask

  task automatic test_flags;
    status = 4'b0001;
    accept(32'h8B020023);
    @(posedge clock);
    #1;
    n_assert++;
    if (flags !== 4'h0) begin n_fail++; $display("FAIL flags.exec: got %h expected 0", flags); end
    status = 4'b1010;
    @(posedge clock);
    #1;
    n_assert++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL flags.load: got %h expected a", flags); end
    status = 4'b0110;
    repeat (2) @(posedge clock);
    #1;
    n_assert++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL flags.hold: got %h expected a", flags); end
  endtask

  task automatic test_add;
    model_instr("add", 32'h8B020023);
    accept(32'h8B020023);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
      if (exp_q.size() > 0) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] tbl [5];
    string       nm  [5];
    tbl[0] = {11'b11001011000, 5'd9, 6'd0, 5'd31, 5'd30}; nm[0] = "sub";
    tbl[1] = {11'b10001010000, 5'd1, 6'd0, 5'd2, 5'd3};   nm[1] = "and";
    tbl[2] = {11'b10101010000, 5'd17, 6'd0, 5'd8, 5'd16}; nm[2] = "orr";
    tbl[3] = 32'h91001404;                                nm[3] = "addi";
    tbl[4] = {10'b1101000100, 12'hFFF, 5'd7, 5'd8};       nm[4] = "subi_max";
    status = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      model_instr(nm[i], tbl[i]);
      accept(tbl[i]);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
        if (exp_q.size() > 0) begin @(posedge clock); #1; end
      end
    end
  endtask

  task automatic test_mem;
    logic [31:0] tbl [4];
    string       nm  [4];
    tbl[0] = 32'hF85F8045;                                 nm[0] = "ldur_m8";
    tbl[1] = 32'hF8010026;                                 nm[1] = "stur_p16";
    tbl[2] = {11'b11111000010, 9'h0FF, 2'b00, 5'd3, 5'd4}; nm[2] = "ldur_p255";
    tbl[3] = {11'b11111000000, 9'h100, 2'b00, 5'd5, 5'd6}; nm[3] = "stur_m256";
    status = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      model_instr(nm[i], tbl[i]);
      accept(tbl[i]);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
        if (exp_q.size() > 0) begin @(posedge clock); #1; end
      end
    end
    n_assert++;
    if (flags !== 4'b1111) begin n_fail++; $display("FAIL mem.flags_held: got %h expected f", flags); end
  endtask

  task automatic test_illegal;
    logic [31:0] tbl [2];
    string       nm  [2];
    tbl[0] = 32'h00000000; nm[0] = "zero";
    tbl[1] = 32'h8B220023; nm[1] = "add_bit21";
    for (int i = 0; i < 2; i++) begin
      model_instr(nm[i], tbl[i]);
      accept(tbl[i]);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
        if (exp_q.size() > 0) begin @(posedge clock); #1; end
      end
    end
  endtask

  // instr_valid stays high with a different word while ADD runs: it must be
  // ignored until IDLE, and the latched ADD must drive EXEC.
  task automatic test_back_to_back;
    model_instr("b2b_add", 32'h8B020023);
    model_instr("b2b_sub", 32'hCB0A0128);
    accept(32'h8B020023);
    instr       = 32'hCB0A0128;
    instr_valid = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
      if (e.tag == "b2b_sub.decode") instr_valid = 1'b0;
      if (exp_q.size() > 0) begin @(posedge clock); #1; end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] ld;
    ld = 32'hF85F8045;
    push_exp("rst_mid.decode", 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    push_exp("rst_mid.mem1", pack_cw(5'd5, 5'd2, 5'd0, 0, 1, FS_ADD, 0, 1, 0, 0, 1, 2'b11, 0, 1),
             64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0);
    push_exp("rst_mid.idle", 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    accept(ld);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
      if (e.tag == "rst_mid.mem1") reset = 1'b1;
      if (exp_q.size() > 0) begin @(posedge clock); #1; end
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      n_assert++;
      if (ControlWord[15] !== 1'b0 || ControlWord[29] !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid.no_write: got cw=%h done=%b expected W=0 WE=0 done=0", ControlWord, done);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_flags();
    test_add();
    test_alu_ops();
    test_mem();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
